// File: rtl/axil_ram_slave.sv
// axil_ram_slave: AXI4-Lite responder in front of a 2^MEM_AW x 32-bit word RAM.
//
// Ports:
//   clock, resetn                  clock and synchronous active-low reset
//   awaddr/awprot/awvalid/awready  write address channel (awprot ignored)
//   wdata/wstrb/wvalid/wready      write data channel, byte lanes by wstrb
//   bvalid/bready/bresp            write response channel
//   araddr/arprot/arvalid/arready  read address channel (arprot ignored)
//   rdata/rresp/rvalid/rready      read data channel, rdata registered
//
// Optional feature: define AXIL_RAM_ERR_EN to answer accesses beyond the RAM
// with SLVERR (no write, zero read data). Without it the word index wraps.
module axil_ram_slave #(
    parameter int          MEM_AW    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] awaddr,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    input  logic [31:0] araddr,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready
);
    typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    logic [31:0] mem [0:(2**MEM_AW)-1];

    wstate_t     ws_q;
    rstate_t     rs_q;
    logic [31:0] awaddr_q, wdata_q, rdata_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  bresp_q, rresp_q;
    logic        bvalid_q, rvalid_q;

    logic        do_write, wok, rok;
    logic [31:0] waddr, wdat, woff, roff;
    logic [3:0]  wstb;

    // Readies come from state alone, never from the incoming valids.
    assign awready = (ws_q == W_IDLE) || (ws_q == W_HAVE_D);
    assign wready  = (ws_q == W_IDLE) || (ws_q == W_HAVE_A);
    assign arready = (rs_q == R_IDLE);
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

    // The committing edge takes whichever half was captured earlier from the
    // holding registers and the other half straight from the bus.
    assign do_write = (ws_q == W_IDLE && awvalid && wvalid) ||
                      (ws_q == W_HAVE_A && wvalid) ||
                      (ws_q == W_HAVE_D && awvalid);
    assign waddr = (ws_q == W_HAVE_A) ? awaddr_q : awaddr;
    assign wdat  = (ws_q == W_HAVE_D) ? wdata_q : wdata;
    assign wstb  = (ws_q == W_HAVE_D) ? wstrb_q : wstrb;
    assign woff  = waddr - BASE_ADDR;
    assign roff  = araddr - BASE_ADDR;

`ifdef AXIL_RAM_ERR_EN
    assign wok = (woff[31:MEM_AW+2] == '0);
    assign rok = (roff[31:MEM_AW+2] == '0);
`else
    assign wok = 1'b1;
    assign rok = 1'b1;
`endif

    logic unused_ok;
    assign unused_ok = &{1'b0, awprot, arprot, woff[1:0], roff[1:0],
                         woff[31:MEM_AW+2], roff[31:MEM_AW+2]};

    // RAM is never reset; a write is suppressed while reset is asserted.
    always_ff @(posedge clock) begin
        if (resetn && do_write && wok)
            for (int i = 0; i < 4; i++)
                if (wstb[i]) mem[woff[MEM_AW+1:2]][8*i +: 8] <= wdat[8*i +: 8];
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            ws_q     <= W_IDLE;
            bvalid_q <= 1'b0;
            bresp_q  <= 2'b00;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            case (ws_q)
                W_IDLE:
                    if (awvalid && !wvalid) begin
                        awaddr_q <= awaddr;
                        ws_q     <= W_HAVE_A;
                    end else if (wvalid && !awvalid) begin
                        wdata_q <= wdata;
                        wstrb_q <= wstrb;
                        ws_q    <= W_HAVE_D;
                    end
                W_RESP:
                    if (bready) begin
                        bvalid_q <= 1'b0;
                        ws_q     <= W_IDLE;
                    end
                default: ;
            endcase
            if (do_write) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wok ? 2'b00 : 2'b10;
                ws_q     <= W_RESP;
            end
        end
    end

    // Reading mem here with non-blocking semantics gives read-before-write
    // when a write to the same word commits on the same edge.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            rs_q     <= R_IDLE;
            rvalid_q <= 1'b0;
            rresp_q  <= 2'b00;
            rdata_q  <= '0;
        end else if (rs_q == R_IDLE) begin
            if (arvalid) begin
                rdata_q  <= rok ? mem[roff[MEM_AW+1:2]] : '0;
                rresp_q  <= rok ? 2'b00 : 2'b10;
                rvalid_q <= 1'b1;
                rs_q     <= R_DATA;
            end
        end else if (rready) begin
            rvalid_q <= 1'b0;
            rs_q     <= R_IDLE;
        end
    end
endmodule

// File: doc/axil_ram_slave.md
Name: axil_ram_slave

Overview:
- AXI4-Lite responder fronting an on-chip word-addressed RAM of 2^MEM_AW x 32 bits.
- Forms the slave end of the core's memory bus; serves instruction fetches and load/store traffic from the core's memory interface.
- Write and read channels are independent. Each channel has one outstanding transaction at most.
- Accepts AW and W in either order or together. Honours byte strobes. Read data is registered.

Parameters:
- MEM_AW, 10, word-index width (RAM depth = 2^MEM_AW words).
- BASE_ADDR, 32'h0000_0000, byte address of word 0.

Ports:
- clock  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- awaddr  in  32  write byte address.
- awprot  in  3  write protection (ignored).
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  32  write data.
- wstrb  in  4  byte-lane enables.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.
- bresp  out  2  write response.
- araddr  in  32  read byte address.
- arprot  in  3  read protection (ignored; arprot[2]=1 marks an instruction fetch).
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  32  read data.
- rresp  out  2  read response.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.

Behaviour:
- Address decode:
  - offset = addr - BASE_ADDR.
  - index = offset[MEM_AW+1:2].
  - offset[1:0] is ignored; lane selection is by wstrb only.
- Reset (resetn=0 at clock edge):
  - Both FSMs go to IDLE.
  - awready=1, wready=1, arready=1.
  - bvalid=0, rvalid=0, bresp=2'b00, rresp=2'b00, rdata=0.
  - RAM contents are not reset.
  - Reset mid-transaction discards any captured address/data; no RAM write occurs.
- Ready signals are decoded from state only. There is no combinational valid-to-ready path.
- Write FSM states: W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP.
  - awready = W_IDLE or W_HAVE_D.
  - wready = W_IDLE or W_HAVE_A.
  - W_IDLE, awvalid and wvalid both high: perform the write at this edge, go to W_RESP.
  - W_IDLE, awvalid only: capture awaddr, go to W_HAVE_A.
  - W_IDLE, wvalid only: capture wdata and wstrb, go to W_HAVE_D.
  - W_HAVE_A, on wvalid: perform the write, go to W_RESP.
  - W_HAVE_D, on awvalid: perform the write, go to W_RESP.
  - W_RESP: bvalid=1 (registered), bresp=2'b00. Hold until bready, then go to W_IDLE, bvalid=0.
  - Back-to-back writes: bvalid falls in the cycle after the B handshake; the next AW/W is accepted from then on.
- Write semantics:
  - Byte lane i of mem[index] is updated iff wstrb[i]=1.
  - wstrb=4'b0000 leaves RAM unchanged but still produces a response.
- Write latency: the accepting edge commits the write; bvalid is high in the following cycle.
- Read FSM states: R_IDLE, R_DATA.
  - arready = R_IDLE.
  - R_IDLE, on arvalid: rdata <= mem[index], rresp <= 2'b00, rvalid <= 1, go to R_DATA.
  - R_DATA: rdata is held stable. On rready, go to R_IDLE and clear rvalid.
  - rdata keeps its last value after the handshake.
- Read latency: 1 cycle from AR handshake to rvalid.
- Same-cycle read and write to the same index: read returns the old contents (read-before-write).
- Read and write channels never stall each other.

Optional Feature:
- Macro: AXIL_RAM_ERR_EN.
- Defined:
  - offset >= 4*2^MEM_AW (unsigned) is out of range.
  - Out-of-range write: RAM not written, bresp=2'b10 (SLVERR).
  - Out-of-range read: rdata=0, rresp=2'b10.
  - Handshake timing is unchanged.
- Undefined:
  - index wraps modulo 2^MEM_AW.
  - bresp and rresp are always 2'b00.

Test Plan:
- Reset, then idle: awready=wready=arready=1; bvalid=rvalid=0; rdata=0.
- AW and W same cycle: addr 0x10, data 0xDEADBEEF, strb 4'hF, bready=1 → bvalid=1 next cycle with bresp=0. Read 0x10 → rvalid one cycle after AR, rdata=0xDEADBEEF.
- Split write, AW first then W 3 cycles later: addr 0x14, data 0x0000AB00, strb 4'b0010, over prior word 0x11223344 → readback 0x1122AB44. Repeat with W before AW → same result. wready=0 while in W_HAVE_D.
- Back-pressure:
  - Hold bready=0 for 5 cycles → bvalid stays 1, awready=wready=0.
  - Hold rready=0 for 5 cycles → rdata stable, arready=0.
- Same-cycle collision: write 0x55555555 to 0x20 (old 0x0) together with AR to 0x20 → rdata=0x0; a following read returns 0x55555555.
- With AXIL_RAM_ERR_EN and MEM_AW=10: write to 0x1000 → bresp=2'b10, word 0 unchanged; read 0x1000 → rresp=2'b10, rdata=0. Without the macro, a read of 0x1000 returns word 0.
- Reset mid-write: assert resetn=0 while in W_HAVE_A → no RAM change, FSM back in W_IDLE.
